// File: rtl/alu4_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : alu4_cmd_issuer
//  Description : Queues ALU commands, drives them one at a time onto a
//                combinational 4-bit ALU and returns the captured result
//                through a valid/ready response register.
//  Revision    : 1.0  initial release
// ============================================================================
module alu4_cmd_issuer #(
    parameter int DEPTH   = 4,
    parameter int CAP_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [3:0]                   cmd_a,
    input  logic [3:0]                   cmd_b,
    input  logic [2:0]                   cmd_sel,
    output logic [3:0]                   alu_a,
    output logic [3:0]                   alu_b,
    output logic [2:0]                   alu_sel,
    input  logic [7:0]                   alu_result,
    input  logic                         alu_carry,
    input  logic                         alu_zero,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [7:0]                   rsp_result,
    output logic                         rsp_carry,
    output logic                         rsp_zero,
    output logic [2:0]                   rsp_sel,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   cmd_count
);

    localparam int                 c_PTR_W  = $clog2(DEPTH);
    localparam int                 c_CNT_W  = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(DEPTH);
    localparam logic [3:0]         c_SETTLE = 4'(CAP_LAT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [10:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [3:0]           r_settle;
    logic                 w_push;
    logic                 w_pop;

    // Ready is a function of registered occupancy only, never of a same-cycle pop.
    assign cmd_ready = (r_count != c_FULL);
    assign w_push    = cmd_valid & cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign cmd_count = r_count;
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {cmd_a, cmd_b, cmd_sel};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_pop) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_WAIT;
            S_WAIT:    if (r_settle == 4'd1) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_HOLD;
            S_HOLD:    if (rsp_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ALU drive holds the last popped command; response fields freeze in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            r_settle   <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_sel    <= '0;
        end else begin
            if (w_pop) begin
                {alu_a, alu_b, alu_sel} <= r_mem[r_rd_ptr];
                r_settle                <= c_SETTLE;
            end else if (r_state == S_WAIT) begin
                r_settle <= r_settle - 1'b1;
            end

            if (r_state == S_CAPTURE) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_zero   <= alu_zero;
                rsp_sel    <= alu_sel;
                rsp_valid  <= 1'b1;
            end else if ((r_state == S_HOLD) && rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu4_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu4_cmd_issuer
//  Description : Bench for alu4_cmd_issuer with a settle time of 1 and of 4,
//                checked against a timestamp-based transaction model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu4_cmd_issuer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LAT0  = 1;
    localparam int LAT1  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          rsp_ready = 1'b0;
    logic [3:0]    cmd_a = '0;
    logic [3:0]    cmd_b = '0;
    logic [2:0]    cmd_sel = '0;

    logic          cmd_ready  [2];
    logic [CW-1:0] cmd_count  [2];
    logic [3:0]    alu_a      [2];
    logic [3:0]    alu_b      [2];
    logic [2:0]    alu_sel    [2];
    logic [7:0]    alu_result [2];
    logic          alu_carry  [2];
    logic          alu_zero   [2];
    logic          rsp_valid  [2];
    logic [7:0]    rsp_result [2];
    logic          rsp_carry  [2];
    logic          rsp_zero   [2];
    logic [2:0]    rsp_sel    [2];
    logic          busy       [2];

    // Reference model: FIFO contents as a shifting list, one in-flight command
    // with the cycle stamp of its pop, and the response it must produce.
    logic [10:0]   m_q    [2][DEPTH];
    int            m_n    [2];
    bit            m_busy [2];
    int            m_t0   [2];
    logic [3:0]    m_a    [2];
    logic [3:0]    m_b    [2];
    logic [2:0]    m_sel  [2];
    bit            m_rv   [2];
    logic [9:0]    m_rsp  [2];
    logic [2:0]    m_rsel [2];
    int            cyc;
    int            n_cmp;
    int            n_fail;

    always #5 clk = ~clk;

    alu4_cmd_issuer #(.DEPTH(DEPTH), .CAP_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_sel[0]),
        .alu_result(alu_result[0]), .alu_carry(alu_carry[0]), .alu_zero(alu_zero[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_result(rsp_result[0]),
        .rsp_carry(rsp_carry[0]), .rsp_zero(rsp_zero[0]), .rsp_sel(rsp_sel[0]),
        .busy(busy[0]), .cmd_count(cmd_count[0])
    );

    alu4_cmd_issuer #(.DEPTH(DEPTH), .CAP_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_sel[1]),
        .alu_result(alu_result[1]), .alu_carry(alu_carry[1]), .alu_zero(alu_zero[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_result(rsp_result[1]),
        .rsp_carry(rsp_carry[1]), .rsp_zero(rsp_zero[1]), .rsp_sel(rsp_sel[1]),
        .busy(busy[1]), .cmd_count(cmd_count[1])
    );

    // Returns {carry, zero, result}; sel 0 is A+B, the rest are arbitrary ops.
    function automatic logic [9:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] sel);
        logic [4:0] s;
        logic [7:0] r;
        logic       c;
        s = '0;
        c = 1'b0;
        case (sel)
            3'd0:    begin s = {1'b0, a} + {1'b0, b}; r = {3'b0, s}; c = s[4]; end
            3'd1:    begin s = {1'b0, a} - {1'b0, b}; r = {3'b0, s}; c = s[4]; end
            3'd2:    r = {4'b0, a & b};
            3'd3:    r = {4'b0, a | b};
            3'd4:    r = {4'b0, a ^ b};
            3'd5:    r = {4'b0, a} * {4'b0, b};
            3'd6:    r = {4'b0, ~a};
            default: r = {3'b0, a, 1'b0};
        endcase
        return {c, (r[3:0] == 4'd0), r};
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++)
            {alu_carry[i], alu_zero[i], alu_result[i]} = alu_f(alu_a[i], alu_b[i], alu_sel[i]);
    end

    function automatic int lat(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_busy[i] = 0; m_t0[i] = 0; m_rv[i] = 0;
            m_a[i] = '0; m_b[i] = '0; m_sel[i] = '0; m_rsp[i] = '0; m_rsel[i] = '0;
        end
    endtask

    task automatic model_edge();
        bit push;
        cyc++;
        if (rst) return;
        for (int i = 0; i < 2; i++) begin
            push = cmd_valid && (m_n[i] != DEPTH);
            if (!m_busy[i]) begin
                if (m_n[i] > 0) begin
                    {m_a[i], m_b[i], m_sel[i]} = m_q[i][0];
                    for (int k = 0; k < DEPTH - 1; k++) m_q[i][k] = m_q[i][k+1];
                    m_n[i]--;
                    m_busy[i] = 1;
                    m_t0[i]   = cyc;
                end
            end else if (!m_rv[i]) begin
                if (cyc - m_t0[i] == lat(i) + 2) begin
                    m_rv[i]   = 1;
                    m_rsp[i]  = alu_f(m_a[i], m_b[i], m_sel[i]);
                    m_rsel[i] = m_sel[i];
                end
            end else if (rsp_ready) begin
                m_rv[i]   = 0;
                m_busy[i] = 0;
            end
            if (push) begin
                m_q[i][m_n[i]] = {cmd_a, cmd_b, cmd_sel};
                m_n[i]++;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d.cmd_ready", i), 32'(cmd_ready[i]), 32'(m_n[i] != DEPTH));
            chk($sformatf("d%0d.cmd_count", i), 32'(cmd_count[i]), m_n[i]);
            chk($sformatf("d%0d.busy", i), 32'(busy[i]), 32'(m_busy[i]));
            chk($sformatf("d%0d.alu_a", i), 32'(alu_a[i]), 32'(m_a[i]));
            chk($sformatf("d%0d.alu_b", i), 32'(alu_b[i]), 32'(m_b[i]));
            chk($sformatf("d%0d.alu_sel", i), 32'(alu_sel[i]), 32'(m_sel[i]));
            chk($sformatf("d%0d.rsp_valid", i), 32'(rsp_valid[i]), 32'(m_rv[i]));
            chk($sformatf("d%0d.rsp_result", i), 32'(rsp_result[i]), 32'(m_rsp[i][7:0]));
            chk($sformatf("d%0d.rsp_carry", i), 32'(rsp_carry[i]), 32'(m_rsp[i][9]));
            chk($sformatf("d%0d.rsp_zero", i), 32'(rsp_zero[i]), 32'(m_rsp[i][8]));
            chk($sformatf("d%0d.rsp_sel", i), 32'(rsp_sel[i]), 32'(m_rsel[i]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((m_busy[0] || m_busy[1] || m_n[0] != 0 || m_n[1] != 0) && k < budget) begin
            tick();
            k++;
        end
        chk("drain.idle", 32'(busy[0] | busy[1]), 32'd0);
    endtask

    task automatic wait_rsp0(input string tag, input int budget);
        int k;
        k = 0;
        while (!rsp_valid[0] && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(rsp_valid[0]), 32'd1);
    endtask

    initial begin
        int got[$];
        n_cmp = 0; n_fail = 0; cyc = 0;
        model_reset();

        // Reset state
        #1 rst = 1'b1;
        #1 check_all();
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single command 3+5 on the CAP_LAT=1 instance
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 4'd3; cmd_b = 4'd5; cmd_sel = 3'd0;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("single.alu_a", 32'(alu_a[0]), 32'd3);
        chk("single.alu_b", 32'(alu_b[0]), 32'd5);
        tick();
        chk("single.valid_p1", 32'(rsp_valid[0]), 32'd0);
        tick();
        chk("single.valid_p2", 32'(rsp_valid[0]), 32'd0);
        tick();
        chk("single.valid_p3", 32'(rsp_valid[0]), 32'd1);
        chk("single.result", 32'(rsp_result[0]), 32'h08);
        chk("single.carry", 32'(rsp_carry[0]), 32'd0);
        chk("single.zero", 32'(rsp_zero[0]), 32'd0);
        chk("single.sel", 32'(rsp_sel[0]), 32'd0);
        drain(50);

        // Carry and zero: F+1
        cmd_valid = 1'b1; cmd_a = 4'hF; cmd_b = 4'h1; cmd_sel = 3'd0;
        tick();
        cmd_valid = 1'b0;
        wait_rsp0("cz.seen", 20);
        chk("cz.result", 32'(rsp_result[0]), 32'h10);
        chk("cz.carry", 32'(rsp_carry[0]), 32'd1);
        chk("cz.zero", 32'(rsp_zero[0]), 32'd1);
        drain(50);

        // FIFO full and ordering with the consumer stalled
        rsp_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cmd_valid = 1'b1; cmd_a = 4'(k); cmd_b = 4'd0; cmd_sel = 3'd0;
            tick();
            if (k == 4) chk("full.ready_k4", 32'(cmd_ready[0]), 32'd1);
            if (k == 5) chk("full.ready_k5", 32'(cmd_ready[0]), 32'd0);
        end
        cmd_valid = 1'b0;
        chk("full.count", 32'(cmd_count[0]), 32'd4);
        wait_rsp0("bp.seen", 20);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp.valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp.result", 32'(rsp_result[0]), 32'h01);
            chk("bp.alu_a", 32'(alu_a[0]), 32'd1);
            chk("bp.count", 32'(cmd_count[0]), 32'd4);
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (rsp_valid[0]) got.push_back(int'(rsp_result[0]));
            tick();
        end
        chk("order.n", got.size(), 32'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("order.%0d", k), (k < got.size()) ? got[k] : -1, k + 1);
        drain(50);

        // Async reset two cycles into WAIT on the CAP_LAT=4 instance
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_a = 4'(7 + k); cmd_b = 4'd2; cmd_sel = 3'd0;
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        chk("rstw.busy_before", 32'(busy[1]), 32'd1);
        chk("rstw.count_before", 32'(cmd_count[1]), 32'd2);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rstw.count", 32'(cmd_count[1]), 32'd0);
        chk("rstw.alu_a", 32'(alu_a[1]), 32'd0);
        chk("rstw.busy", 32'(busy[1]), 32'd0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("rstw.no_rsp1", 32'(rsp_valid[1]), 32'd0);
            chk("rstw.no_rsp0", 32'(rsp_valid[0]), 32'd0);
        end

        // Randomized traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_a     = 4'($urandom_range(0, 15));
            cmd_b     = 4'($urandom_range(0, 15));
            cmd_sel   = 3'($urandom_range(0, 7));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        drain(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu4_cmd_issuer.md
Name: alu4_cmd_issuer

Overview:
- Initiator side of the 4-bit ALU operand/select/result interface.
- Queues operation commands in a small FIFO and drives one command at a time onto the ALU operand and select lines.
- Waits a fixed settle time, then captures result, carry and zero into a response register with a valid/ready handshake.
- Sits between a host or test sequencer and the combinational ALU.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2 or more.
- CAP_LAT, 1, settle cycles between driving the ALU and capturing its outputs; 1 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command (not full).
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_sel  in  3  operation select.
- alu_a  out  4  operand A driven to the ALU.
- alu_b  out  4  operand B driven to the ALU.
- alu_sel  out  3  select driven to the ALU.
- alu_result  in  8  ALU result.
- alu_carry  in  1  ALU carry flag.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  8  captured result.
- rsp_carry  out  1  captured carry.
- rsp_zero  out  1  captured zero.
- rsp_sel  out  3  select of the captured operation (echo).
- busy  out  1  FSM not in IDLE.
- cmd_count  out  clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async assert, sync-safe release):
  - FIFO emptied, so cmd_count=0 and cmd_ready=1.
  - FSM to IDLE.
  - alu_a, alu_b, alu_sel, rsp_* all 0; rsp_valid=0; busy=0.
- FIFO:
  - Push when cmd_valid & cmd_ready; pop only from IDLE.
  - cmd_ready = (cmd_count != DEPTH), registered-state only; it does not depend on a same-cycle pop.
  - Simultaneous push and pop leaves cmd_count unchanged, including when the FIFO is at DEPTH-1.
  - Pointers wrap modulo DEPTH.
  - cmd_valid while full is ignored (no push, no corruption).
- FSM states IDLE, ISSUE, WAIT, CAPTURE, HOLD:
  - IDLE: if FIFO non-empty, pop the head, register it onto alu_a/alu_b/alu_sel, load the settle counter with CAP_LAT, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: one cycle with operands stable at the ALU; go to WAIT.
  - WAIT: decrement the counter each cycle; at 1, go to CAPTURE. So a total of CAP_LAT cycles are spent in WAIT.
  - CAPTURE: sample alu_result, alu_carry, alu_zero and the current alu_sel into rsp_*; set rsp_valid; go to HOLD.
  - HOLD: when rsp_ready=1, clear rsp_valid next edge and go to IDLE.
- alu_a, alu_b, alu_sel hold the last issued command until the next pop; they never glitch between commands.
- rsp_result, rsp_carry, rsp_zero, rsp_sel are stable while rsp_valid=1.
- rsp_valid falls only via handshake or reset.
- rsp_ready=1 outside HOLD has no effect.
- Latency, from the pop edge in IDLE to rsp_valid=1, is CAP_LAT+2 cycles.
- Minimum command period is CAP_LAT+4 cycles when rsp_ready is held at 1.
- Commands are issued strictly in FIFO order; exactly one response per accepted command.
- Reset mid-operation (any state) discards the in-flight command and all queued commands; no response is produced for them.
- The block does not interpret cmd_sel; the ALU model defines the operation.

Test Plan:
- Bench ALU model: sel 000 = A+B, with carry = sum bit 4 and zero = (sum[3:0]==0).
- Single command: after reset push A=3, B=5, sel=000 with rsp_ready=1 and CAP_LAT=1.
  - Expect alu_a=3 and alu_b=5 one edge after the pop.
  - Expect rsp_valid high 3 cycles after the pop, with rsp_result=8'h08, rsp_carry=0, rsp_zero=0, rsp_sel=000.
- Carry/zero: push A=4'hF, B=4'h1, sel=000.
  - Expect rsp_result=8'h10, rsp_carry=1, rsp_zero=1.
- FIFO full and ordering: hold rsp_ready=0 and push 6 commands, A=1..6 with B=0.
  - cmd_ready must drop after 4 + 1 accepted; cmd_count=4.
  - The sixth command is rejected.
  - Release rsp_ready: responses arrive in order with results 1,2,3,4,5; no response for 6.
- Backpressure: hold rsp_ready=0 for 10 cycles in HOLD.
  - rsp_* must stay constant; no new ALU drive.
  - Next command is issued only after the handshake.
- Async reset mid-WAIT: with CAP_LAT=4, assert rst between clock edges two cycles into WAIT with 2 commands queued.
  - All outputs go to 0 immediately; cmd_count=0.
  - No rsp_valid after release until new commands are pushed.
